// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: the MD op encoding
// produced by EX control, default latencies and a small op classifier.
package mdu_pkg;

  // MD-class operation encoding carried on the 3-bit op bus.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage. Computes mult/div results in the
// accept cycle, parks them in a pending register and commits them to HI/LO
// after a fixed latency, so the pipeline sees a multi-cycle unit.
//
// Handshake: an op is accepted at a rising edge when start=1 and busy=0.
// While busy=1, start is ignored with no state change; the upstream stage
// must hold (stall) the MD instruction until busy drops. busy is high for
// exactly MULT_CYCLES/DIV_CYCLES cycles after a long op is accepted, and the
// new HI/LO are visible in the first cycle busy reads 0.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;

  logic [63:0]      w_prod_s, w_prod_u;
  logic             w_div_signed, w_a_neg, w_b_neg, w_b_zero;
  logic [31:0]      w_a_mag, w_b_mag, w_den, w_q_mag, w_r_mag, w_quo, w_rem;
  logic [31:0]      w_res_hi, w_res_lo;
  logic [CNT_W-1:0] w_cnt_load;
  logic             w_wr_hi, w_wr_lo;

  // Full 64-bit products; operands are sign- or zero-extended first.
  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Division on magnitudes, then sign fix-up: quotient truncates toward
  // zero, remainder follows the dividend. This also yields 0x80000000 for
  // the most-negative / -1 case without relying on signed-divide overflow.
  assign w_div_signed = (op == MD_DIV);
  assign w_a_neg      = w_div_signed & A[31];
  assign w_b_neg      = w_div_signed & B[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag      = w_b_neg ? (32'd0 - B) : B;
  assign w_b_zero     = (B == 32'd0);
  assign w_den        = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_den;
  assign w_r_mag      = w_a_mag % w_den;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Decode op into pending result, latency to load and direct HI/LO writes.
  always_comb begin
    w_res_hi   = r_pend_hi;
    w_res_lo   = r_pend_lo;
    w_cnt_load = '0;
    w_wr_hi    = 1'b0;
    w_wr_lo    = 1'b0;
    case (op)
      MD_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_cnt_load           = C_MULT;
      end
      MD_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_cnt_load           = C_MULT;
      end
      MD_DIV, MD_DIVU: begin
        // Divide by zero leaves HI/LO as they are, but still takes the time.
        w_res_hi   = w_b_zero ? r_hi : w_rem;
        w_res_lo   = w_b_zero ? r_lo : w_quo;
        w_cnt_load = C_DIV;
      end
      MD_MTHI: w_wr_hi = 1'b1;
      MD_MTLO: w_wr_lo = 1'b1;
      default: ;
    endcase
  end

  // Accept, countdown and commit of HI/LO; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_ONE;
      if (r_cnt == C_ONE) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      if (is_long_op(op)) begin
        r_cnt     <= w_cnt_load;
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
      end
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  assign busy = (r_cnt != '0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu: a timeline-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_smul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x;
  endfunction

  function automatic logic [63:0] m_umul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned x;
    x = a;
    x = x * b;
    return x;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] m_sdiv(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] m_udiv(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, q, r;
    ua = a;
    ub = b;
    q  = ua / ub;
    r  = ua % ub;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: a free-running cycle index; a long op schedules its result for
  // commit at (accept cycle + latency) and the unit is busy until then.
  logic        m_pending;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_cyc, m_ready_at;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending  <= 1'b0;
      m_hi       <= '0;
      m_lo       <= '0;
      m_phi      <= '0;
      m_plo      <= '0;
      m_cyc      <= 0;
      m_ready_at <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_pending && (m_cyc + 1 == m_ready_at)) begin
        m_hi      <= m_phi;
        m_lo      <= m_plo;
        m_pending <= 1'b0;
      end
      if (start && !m_pending) begin
        case (op)
          MD_MULT, MD_MULTU: begin
            {m_phi, m_plo} <= (op == MD_MULT) ? m_smul(A, B) : m_umul(A, B);
            m_pending      <= 1'b1;
            m_ready_at     <= m_cyc + 1 + MULT_N;
          end
          MD_DIV, MD_DIVU: begin
            if (B == 32'd0) {m_phi, m_plo} <= {m_hi, m_lo};
            else {m_phi, m_plo} <= (op == MD_DIV) ? m_sdiv(A, B) : m_udiv(A, B);
            m_pending  <= 1'b1;
            m_ready_at <= m_cyc + 1 + DIV_N;
          end
          MD_MTHI: m_hi <= A;
          MD_MTLO: m_lo <= A;
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_pending});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    op    = MD_NONE;
  endtask

  // Counts busy cycles after an accept; bounded so a stuck busy still ends.
  task automatic wait_idle(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
    check(name, 32'(cnt), 32'(exp_cycles));
  endtask

  logic [2:0]  vec_op[6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MULT, MD_DIV};
  logic [31:0] vec_a[6]  = '{32'h7FFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFFFF,
                             32'h80000000, 32'h80000000};
  logic [31:0] vec_b[6]  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'd10,
                             32'hFFFFFFFF, 32'd3};

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = MD_NONE;
    A     = '0;
    B     = '0;
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    rst = 1'b1;
    step();
    chk_en = 1'b1;

    // Signed multiply: -3 * 5 = -15.
    do_op(MD_MULT, 32'hFFFFFFFD, 32'd5);
    wait_idle("mult_busy_len", MULT_N);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);

    // Unsigned multiply; operands wiggled while busy must not matter.
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    A = 32'($urandom);
    B = 32'($urandom);
    wait_idle("multu_busy_len", MULT_N);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);

    // Signed divide: -7 / 2 = -3 rem -1.
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_busy_len", DIV_N);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // Divide by zero: still busy, HI/LO unchanged.
    do_op(MD_DIVU, 32'd7, 32'd0);
    wait_idle("divz_busy_len", DIV_N);
    check("divz_lo", LO, 32'hFFFFFFFD);
    check("divz_hi", HI, 32'hFFFFFFFF);

    // Most-negative / -1.
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("ovf_busy_len", DIV_N);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h00000000);

    // MTHI during a multiply is ignored; product 0x10000 * 0x30000 = 3 << 32.
    do_op(MD_MULT, 32'h00010000, 32'h00030000);
    do_op(MD_MTHI, 32'h00001234, 32'd0);
    wait_idle("ign_busy_len", MULT_N - 1);
    check("ign_hi", HI, 32'h00000003);
    check("ign_lo", LO, 32'h00000000);
    do_op(MD_MTHI, 32'h00001234, 32'd0);
    check("mthi_hi", HI, 32'h00001234);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // Reserved op has no effect.
    do_op(MD_RSVD, 32'hDEADBEEF, 32'd1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", HI, 32'h00001234);

    // Asynchronous reset three cycles into a divide.
    do_op(MD_DIV, 32'd100, 32'd7);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    step();
    rst = 1'b1;
    repeat (12) step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    // Back-to-back MTLO then MULT 2*3.
    start = 1'b1;
    op    = MD_MTLO;
    A     = 32'hAAAA5555;
    step();
    check("b2b_mtlo", LO, 32'hAAAA5555);
    op = MD_MULT;
    A  = 32'd2;
    B  = 32'd3;
    step();
    start = 1'b0;
    op    = MD_NONE;
    wait_idle("b2b_busy_len", MULT_N);
    check("b2b_lo", LO, 32'd6);
    check("b2b_hi", HI, 32'd0);

    // Extra directed vectors, checked by the per-cycle model.
    for (int i = 0; i < 6; i++) begin
      do_op(vec_op[i], vec_a[i], vec_b[i]);
      wait_idle("vec_busy_len", (vec_op[i] == MD_DIV || vec_op[i] == MD_DIVU) ? DIV_N : MULT_N);
    end
    // Last vector: 0x80000000 / 3 = -715827882 rem -2.
    check("vec_div_lo", LO, 32'hD5555556);
    check("vec_div_hi", HI, 32'hFFFFFFFE);

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
